uart_rx_byte: RTL
=================

UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning CLK frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning serial bit rate; BPS_CNT = CLK_FREQ/BAUD (integer division), HALF_CNT = BPS_CNT/2.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port RSTn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RX_Pin_In  input  1  asynchronous serial line, idle high, 8N1 LSB-first.
REQ-006 SHALL have port RX_En_Sig  input  1  receive enable from the downstream command parser.
REQ-007 SHALL have port RX_Data  output  8  last correctly framed byte.
REQ-008 SHALL have port RX_Done_Sig  output  1  one-cycle strobe, RX_Data valid.
REQ-009 SHALL have port RX_Err_Sig  output  1  one-cycle strobe, framing error (stop bit low).

Function
REQ-010 SHALL pass RX_Pin_In through a 2-flop synchronizer plus a third flop for edge detect; all decisions use the synchronized value.
REQ-011 SHALL use states IDLE, START, DATA, STOP, DONE.
REQ-012 IDLE: leave for START only when RX_En_Sig=1 and a falling edge is detected (previous=1, current=0); the baud counter clears on entry to START.
REQ-013 START: at baud count HALF_CNT-1, sample the line; if 0, enter DATA with counter cleared; if 1 (glitch), return to IDLE with no strobe.
REQ-014 DATA: at each baud count BPS_CNT-1, shift the sampled bit into bit position [bit_idx], LSB first; after the 8th bit, enter STOP.
REQ-015 STOP: at baud count BPS_CNT-1, sample; if 1, load the shift register into RX_Data and enter DONE; if 0, pulse RX_Err_Sig for exactly one cycle, leave RX_Data unchanged and return to IDLE.
REQ-016 DONE: assert RX_Done_Sig for exactly one cycle, then go to IDLE; total latency is start-edge to strobe ≈ 9.5 bit periods + 4 cycles.
REQ-017 The baud counter SHALL be ceil(log2(BPS_CNT)) bits wide, count 0..BPS_CNT-1, and wrap to 0.
REQ-018 RX_Data SHALL hold its value until the next successful frame.
REQ-019 When RX_En_Sig falls while the block is in START, DATA or STOP, it SHALL abort to IDLE next cycle with no strobe and RX_Data unchanged.
REQ-020 RX_Done_Sig and RX_Err_Sig SHALL never be asserted in the same cycle.
REQ-021 A falling edge that arrives during DONE SHALL be ignored; the frame must start from IDLE.

Reset
REQ-022 On RSTn=0: state=IDLE, counters=0, shift register=0, RX_Data=8'h00, RX_Done_Sig=0, RX_Err_Sig=0, synchronizer flops=1 (idle line).
REQ-023 Reset asserted mid-frame SHALL discard the frame; after release, reception resumes only on a new falling edge.

Structure
REQ-024 State encoding and the BPS_CNT/HALF_CNT derivation SHALL live in a shared uart package reused by the future TX block.
REQ-025 A single sub-module, uart_baud_cnt (counter with clear and terminal-count outputs at HALF and FULL), is natural; everything else stays in one module.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, BPS_CNT=10)
REQ-026 RX_En_Sig=1, send 8'hA5 with a valid stop -> one RX_Done_Sig pulse, RX_Data=8'hA5, RX_Err_Sig stays 0.
REQ-027 Send 8'h01, 8'h03, 8'hE8 back-to-back with one stop bit each -> three Done pulses carrying 01, 03, E8 in order.
REQ-028 Send 8'h3C with stop bit 0 -> one RX_Err_Sig pulse, no Done, RX_Data keeps its prior value.
REQ-029 3-cycle low glitch on an idle line -> no strobe, state back in IDLE before the 6th cycle.
REQ-030 RX_En_Sig=0 while sending 8'h55 -> no strobe; drop RX_En_Sig during bit 3 of a frame -> abort, no strobe; next frame 8'h7E is received correctly.
REQ-031 Assert RSTn=0 during bit 5, release, then send 8'h81 -> only 8'h81 is reported; all outputs were at their reset values during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and baud-rate derivation
package uart_pkg;

    // Receiver/transmitter frame states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } uart_state_t;

    // Bits per frame payload (8N1)
    localparam int UART_DATA_BITS = 8;

    // Clock cycles per serial bit
    function automatic int calc_bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Clock cycles to the middle of the start bit
    function automatic int calc_half_cnt(input int clk_freq, input int baud);
        return (clk_freq / baud) / 2;
    endfunction

    // Baud counter width; never narrower than one bit
    function automatic int calc_cnt_w(input int bps_cnt);
        return (bps_cnt <= 1) ? 1 : $clog2(bps_cnt);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - baud counter with clear and half/full terminal counts
module uart_baud_cnt #(
    parameter int BPS_CNT  = 10,
    parameter int HALF_CNT = 5,
    parameter int CNT_W    = 4
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clr,
    output logic o_half_tc,
    output logic o_full_tc
);

    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(HALF_CNT - 1);
    localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(BPS_CNT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    assign w_full    = (r_cnt == FULL_TC);
    assign o_half_tc = (r_cnt == HALF_TC);
    assign o_full_tc = w_full;

    // Free-running count 0..BPS_CNT-1 with wrap; clear wins over counting
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else if (i_clr || w_full) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with framing-error strobe
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       RX_Pin_In,
    input  logic       RX_En_Sig,
    output logic [7:0] RX_Data,
    output logic       RX_Done_Sig,
    output logic       RX_Err_Sig
);

    localparam int BPS_CNT  = calc_bps_cnt(CLK_FREQ, BAUD);
    localparam int HALF_CNT = calc_half_cnt(CLK_FREQ, BAUD);
    localparam int CNT_W    = calc_cnt_w(BPS_CNT);

    // Synchronizer and edge-detect flops; all reset to the idle-high line level
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;

    logic        w_rx;
    logic        w_fall;
    logic        w_cnt_clr;
    logic        w_half_tc;
    logic        w_full_tc;

    uart_state_t r_state;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_done;
    logic        r_err;

    assign w_rx   = r_rx_sync;
    assign w_fall = r_rx_prev & ~r_rx_sync;

    // Counter idles at zero outside a frame and restarts at the start-bit midpoint
    assign w_cnt_clr = (r_state == S_IDLE) || (r_state == S_DONE) ||
                       ((r_state == S_START) && w_half_tc);

    uart_baud_cnt #(
        .BPS_CNT  (BPS_CNT),
        .HALF_CNT (HALF_CNT),
        .CNT_W    (CNT_W)
    ) u_baud_cnt (
        .i_clk     (CLK),
        .i_rstn    (RSTn),
        .i_clr     (w_cnt_clr),
        .o_half_tc (w_half_tc),
        .o_full_tc (w_full_tc)
    );

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX_Pin_In;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Frame FSM with registered data and one-cycle done/error strobes
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state   <= S_IDLE;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_rx_data <= 8'h00;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (RX_En_Sig && w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (!RX_En_Sig) begin
                        r_state <= S_IDLE;
                    end else if (w_half_tc) begin
                        // A high line at mid start bit means the edge was a glitch
                        if (!w_rx) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (!RX_En_Sig) begin
                        r_state <= S_IDLE;
                    end else if (w_full_tc) begin
                        r_shift[r_bit_idx] <= w_rx;
                        if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (!RX_En_Sig) begin
                        r_state <= S_IDLE;
                    end else if (w_full_tc) begin
                        if (w_rx) begin
                            r_rx_data <= r_shift;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    // Done strobe is high for this single cycle; edges here are ignored
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign RX_Data     = r_rx_data;
    assign RX_Done_Sig = r_done;
    assign RX_Err_Sig  = r_err;

endmodule
